// File: rtl/div32_sequential.sv
// -----------------------------------------------------------------------------
// div32_sequential
//
// Multi-cycle restoring radix-2 divider with RISC-V DIV/DIVU/REM/REMU
// semantics. All state updates happen on the falling edge of clk so the block
// lines up with the multiplier pipeline timing. Reset is asynchronous and
// active-high.
//
// Handshake: start is sampled only when the block is idle (busy=0). The edge
// that accepts it also captures X, Y and signed_div_i, so the caller may change
// them afterwards. busy stays high until the result is produced. result_rdy is
// a one-cycle pulse marking Quotient/Remainder valid. Quotient and Remainder
// then hold their values until the next result or reset. A start while busy is
// ignored. The earliest accepted start is on the edge after result_rdy.
//
// Ports
//   clk          : clock; state updates on its falling edge
//   rst          : asynchronous active-high reset
//   start        : request a division (sampled in IDLE only)
//   signed_div_i : 1 = signed (DIV/REM), 0 = unsigned (DIVU/REMU)
//   X            : dividend
//   Y            : divisor
//   busy         : high while a division is in flight
//   result_rdy   : one-cycle pulse, Quotient/Remainder valid
//   Quotient     : registered quotient
//   Remainder    : registered remainder
// -----------------------------------------------------------------------------
module div32_sequential #(
    parameter int OPERAND_SIZE = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    signed_div_i,
    input  logic [OPERAND_SIZE-1:0] X,
    input  logic [OPERAND_SIZE-1:0] Y,
    output logic                    busy,
    output logic                    result_rdy,
    output logic [OPERAND_SIZE-1:0] Quotient,
    output logic [OPERAND_SIZE-1:0] Remainder
);

    localparam int W  = OPERAND_SIZE;
    localparam int CW = $clog2(W) + 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIVIDE = 2'd1,
        FIXUP  = 2'd2
    } state_t;

    state_t        state;
    logic [CW-1:0] count;
    logic [W-1:0]  dvd;      // dividend shifts out the top, quotient bits shift in
    logic [W-1:0]  rem;      // partial remainder
    logic [W-1:0]  dsr;      // divisor magnitude
    logic          q_neg;
    logic          r_neg;

    // Operand conditioning at the accept edge.
    logic          x_neg;
    logic          y_neg;
    logic [W-1:0]  x_mag;
    logic [W-1:0]  y_mag;
    logic          div_zero;
    logic          sgn_ovf;

    assign x_neg    = signed_div_i & X[W-1];
    assign y_neg    = signed_div_i & Y[W-1];
    assign x_mag    = x_neg ? -X : X;
    assign y_mag    = y_neg ? -Y : Y;
    assign div_zero = (Y == '0);
    assign sgn_ovf  = signed_div_i && (X == {1'b1, {(W-1){1'b0}}}) && (Y == '1);

    // One restoring step. The partial remainder is always below the divisor,
    // so the shifted value minus the divisor lies in (-2^W, 2^W) and a W+1 bit
    // subtraction carries the correct sign in its top bit.
    logic [W:0]    shifted;
    logic [W:0]    trial;
    logic          neg_trial;

    assign shifted   = {rem, dvd[W-1]};
    assign trial     = shifted - {1'b0, dsr};
    assign neg_trial = trial[W];

    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            busy       <= 1'b0;
            result_rdy <= 1'b0;
            Quotient   <= '0;
            Remainder  <= '0;
            count      <= '0;
            dvd        <= '0;
            rem        <= '0;
            dsr        <= '0;
            q_neg      <= 1'b0;
            r_neg      <= 1'b0;
        end else begin
            result_rdy <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        busy  <= 1'b1;
                        count <= '0;
                        if (div_zero) begin
                            // Preload the final values; FIXUP passes them through.
                            dvd   <= '1;
                            rem   <= X;
                            dsr   <= '0;
                            q_neg <= 1'b0;
                            r_neg <= 1'b0;
                            state <= FIXUP;
                        end else if (sgn_ovf) begin
                            dvd   <= X;
                            rem   <= '0;
                            dsr   <= Y;
                            q_neg <= 1'b0;
                            r_neg <= 1'b0;
                            state <= FIXUP;
                        end else begin
                            dvd   <= x_mag;
                            rem   <= '0;
                            dsr   <= y_mag;
                            q_neg <= x_neg ^ y_neg;
                            r_neg <= x_neg;
                            state <= DIVIDE;
                        end
                    end
                end
                DIVIDE: begin
                    dvd   <= {dvd[W-2:0], ~neg_trial};
                    rem   <= neg_trial ? shifted[W-1:0] : trial[W-1:0];
                    count <= count + CW'(1);
                    if (count == CW'(W - 1)) begin
                        state <= FIXUP;
                    end
                end
                FIXUP: begin
                    Quotient   <= q_neg ? -dvd : dvd;
                    Remainder  <= r_neg ? -rem : rem;
                    result_rdy <= 1'b1;
                    busy       <= 1'b0;
                    state      <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div32_sequential.sv
// -----------------------------------------------------------------------------
// tb_div32_sequential
//
// Directed and randomized checks of div32_sequential against an arithmetic
// reference model (plain / and % with the RISC-V special cases).
// -----------------------------------------------------------------------------
module tb_div32_sequential;

    localparam int W = 32;

    logic         clk;
    logic         rst;
    logic         start;
    logic         signed_div_i;
    logic [W-1:0] X;
    logic [W-1:0] Y;
    logic         busy;
    logic         result_rdy;
    logic [W-1:0] Quotient;
    logic [W-1:0] Remainder;

    int checks   = 0;
    int failures = 0;

    logic [W-1:0] exp_q[$];

    div32_sequential #(.OPERAND_SIZE(W)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .signed_div_i (signed_div_i),
        .X            (X),
        .Y            (Y),
        .busy         (busy),
        .result_rdy   (result_rdy),
        .Quotient     (Quotient),
        .Remainder    (Remainder)
    );

    // Clock / reset block: DUT acts on falling edges, bench samples #1 after.
    initial begin
        clk = 1'b1;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference model: RISC-V division semantics from plain arithmetic.
    task automatic model(input logic [W-1:0] x, input logic [W-1:0] y, input logic s,
                         output logic [W-1:0] q, output logic [W-1:0] r, output int lat);
        if (y == 0) begin
            q   = '1;
            r   = x;
            lat = 1;
        end else if (s && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
            q   = 32'h8000_0000;
            r   = 0;
            lat = 1;
        end else if (s) begin
            q   = $signed(x) / $signed(y);
            r   = $signed(x) % $signed(y);
            lat = W + 1;
        end else begin
            q   = x / y;
            r   = x % y;
            lat = W + 1;
        end
    endtask

    // Driver: one division. inject>0 raises a stray start before that edge.
    task automatic run_div(input logic [W-1:0] x, input logic [W-1:0] y, input logic s,
                           input int inject, input string tag);
        logic [W-1:0] eq;
        logic [W-1:0] er;
        int           lat;
        int           seen_at;
        logic         busy_ok;
        model(x, y, s, eq, er, lat);
        exp_q.push_back(eq);
        exp_q.push_back(er);
        @(posedge clk);
        start        = 1'b1;
        X            = x;
        Y            = y;
        signed_div_i = s;
        @(negedge clk);
        #1;
        start        = 1'b0;
        X            = $urandom;
        Y            = $urandom;
        signed_div_i = 1'($urandom_range(0, 1));
        check({tag, "_busy_at_accept"}, W'(busy), W'(1));
        seen_at = 0;
        busy_ok = 1'b1;
        for (int e = 1; e <= W + 8 && seen_at == 0; e++) begin
            if (e == inject) begin
                start        = 1'b1;
                X            = 5;
                Y            = 5;
                signed_div_i = 1'b0;
            end
            @(negedge clk);
            #1;
            start = 1'b0;
            if (result_rdy) seen_at = e;
            else if (!busy) busy_ok = 1'b0;
        end
        check({tag, "_latency"}, W'(seen_at), W'(lat));
        check({tag, "_busy_throughout"}, W'(busy_ok), W'(1));
        check({tag, "_busy_at_rdy"}, W'(busy), W'(0));
        eq = exp_q.pop_front();
        er = exp_q.pop_front();
        check({tag, "_quotient"}, Quotient, eq);
        check({tag, "_remainder"}, Remainder, er);
        @(negedge clk);
        #1;
        check({tag, "_rdy_pulse"}, W'(result_rdy), W'(0));
        check({tag, "_idle_after"}, W'(busy), W'(0));
        check({tag, "_q_hold"}, Quotient, eq);
        check({tag, "_r_hold"}, Remainder, er);
    endtask

    initial begin
        logic [W-1:0] rx;
        logic [W-1:0] ry;
        logic         rs;
        int           inj;
        int           no_rdy;

        rst          = 1'b0;
        start        = 1'b0;
        signed_div_i = 1'b0;
        X            = '0;
        Y            = '0;
        #3;
        rst = 1'b1;
        #1;
        check("reset_busy", W'(busy), W'(0));
        check("reset_rdy", W'(result_rdy), W'(0));
        check("reset_q", Quotient, W'(0));
        check("reset_r", Remainder, W'(0));
        repeat (2) @(negedge clk);
        #2;
        rst = 1'b0;

        run_div(32'd100, 32'd7, 1'b0, 0, "udiv_100_7");
        run_div(32'hFFFF_FFF9, 32'd2, 1'b1, 0, "sdiv_m7_2");
        run_div(32'hFFFF_FFF9, 32'd2, 1'b0, 0, "udiv_m7_2");
        run_div(32'h1234_5678, 32'd0, 1'b0, 0, "udiv_zero");
        run_div(32'h1234_5678, 32'd0, 1'b1, 0, "sdiv_zero");
        run_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 0, "sdiv_ovf");
        run_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 0, "udiv_ovf");
        run_div(32'd7, 32'hFFFF_FFFE, 1'b1, 0, "sdiv_7_m2");
        run_div(32'hFFFF_FFFF, 32'd1, 1'b0, 0, "udiv_max_1");
        run_div(32'd1000, 32'd10, 1'b0, 10, "start_ignored");
        run_div(32'd77, 32'd0, 1'b0, 1, "start_in_fixup_bypass");
        run_div(32'd77, 32'd5, 1'b1, W + 1, "start_in_fixup");

        // Reset in the middle of a division.
        @(posedge clk);
        start        = 1'b1;
        X            = 32'd1000;
        Y            = 32'd10;
        signed_div_i = 1'b0;
        @(negedge clk);
        #1;
        start = 1'b0;
        repeat (11) @(negedge clk);
        #1;
        check("abort_busy_before", W'(busy), W'(1));
        #2;
        rst = 1'b1;
        #1;
        check("abort_busy", W'(busy), W'(0));
        check("abort_rdy", W'(result_rdy), W'(0));
        check("abort_q", Quotient, W'(0));
        check("abort_r", Remainder, W'(0));
        @(negedge clk);
        #1;
        rst    = 1'b0;
        no_rdy = 1;
        for (int e = 0; e < W + 4; e++) begin
            @(negedge clk);
            #1;
            if (result_rdy || busy) no_rdy = 0;
        end
        check("abort_no_rdy", W'(no_rdy), W'(1));
        run_div(32'd9, 32'd3, 1'b0, 0, "after_abort");

        // Randomized operations.
        for (int n = 0; n < 24; n++) begin
            rs = 1'($urandom_range(0, 1));
            rx = $urandom;
            case ($urandom_range(0, 9))
                0:       ry = 0;
                1:       begin rx = 32'h8000_0000; ry = 32'hFFFF_FFFF; end
                2, 3:    ry = W'($urandom_range(1, 15));
                4:       ry = -W'($urandom_range(1, 15));
                default: ry = $urandom >> $urandom_range(0, 31);
            endcase
            case ($urandom_range(0, 3))
                0:       inj = W + 1;
                1:       inj = $urandom_range(1, W);
                default: inj = 0;
            endcase
            run_div(rx, ry, rs, inj, $sformatf("rand%0d", n));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/div32_sequential.md
DIV32_SEQUENTIAL -- requirements
Module: div32_sequential

Interface
REQ-001 SHALL have parameter OPERAND_SIZE, default 32, giving the operand, quotient and remainder width.
REQ-002 SHALL have port clk  input  1  clock; all state updates occur on the falling edge of clk, matching the multiplier pipeline timing.
REQ-003 SHALL have port rst  input  1  reset; one clock; reset is asynchronous and active-high.
REQ-004 SHALL have port start  input  1  request a division; sampled only in IDLE.
REQ-005 SHALL have port signed_div_i  input  1  1 = signed (DIV/REM), 0 = unsigned (DIVU/REMU); sampled with start.
REQ-006 SHALL have port X  input  OPERAND_SIZE  dividend; sampled with start.
REQ-007 SHALL have port Y  input  OPERAND_SIZE  divisor; sampled with start.
REQ-008 SHALL have port busy  output  1  high whenever the state is not IDLE.
REQ-009 SHALL have port result_rdy  output  1  one-cycle pulse marking Quotient/Remainder valid.
REQ-010 SHALL have port Quotient  output  OPERAND_SIZE  registered quotient.
REQ-011 SHALL have port Remainder  output  OPERAND_SIZE  registered remainder.

Function
REQ-012 SHALL implement an FSM with states IDLE, DIVIDE and FIXUP.
REQ-013 In IDLE with start=1 at a falling edge ("accept edge"), SHALL capture X, Y and signed_div_i, so the inputs may change afterwards.
REQ-014 At the accept edge SHALL store magnitudes: |X| and |Y| when signed, raw values otherwise.
REQ-015 At the accept edge SHALL record sign flags q_neg = X[MSB]^Y[MSB] and r_neg = X[MSB], both only when signed.
REQ-016 At the accept edge, for a normal operation, SHALL go to DIVIDE with iteration counter = 0.
REQ-017 In DIVIDE, each edge SHALL perform one restoring radix-2 step.
- Step: shift {partial remainder, dividend} left by 1; trial-subtract the divisor magnitude.
- Non-negative trial result: keep the difference; quotient bit = 1.
- Negative trial result: restore; quotient bit = 0.
- Subtraction is OPERAND_SIZE+1 bits wide.
REQ-018 After exactly OPERAND_SIZE DIVIDE edges SHALL enter FIXUP.
REQ-019 In FIXUP, SHALL register Quotient and Remainder, applying two's-complement negation where q_neg/r_neg is set.
REQ-020 In FIXUP, SHALL assert result_rdy for exactly one cycle and return to IDLE.
REQ-021 Normal latency: result_rdy SHALL go high OPERAND_SIZE+1 edges after the accept edge (33 for the default).
REQ-022 Divide-by-zero (Y=0, either mode): at the accept edge SHALL skip DIVIDE and go to FIXUP.
- Result: Quotient = all ones, Remainder = X unmodified.
- result_rdy goes high 1 edge after the accept edge.
REQ-023 Signed overflow (signed, X = 0x80000000, Y = 0xFFFFFFFF): SHALL take the same 1-edge bypass.
- Result: Quotient = 0x80000000, Remainder = 0.
REQ-024 Remainder sign SHALL follow the dividend; quotient SHALL truncate toward zero (RISC-V semantics).
REQ-025 start while busy=1, including in FIXUP, SHALL be ignored with no effect on the in-flight result.
- A new start is accepted only from IDLE, i.e. no earlier than the edge after result_rdy.
REQ-026 Quotient and Remainder SHALL hold their last values until the next FIXUP or reset.
- They are not cleared when result_rdy drops.
REQ-027 result_rdy and busy SHALL be registered outputs with no combinational path from start.

Reset
REQ-028 rst=1 SHALL immediately force state IDLE, busy=0, result_rdy=0, Quotient=0, Remainder=0, counter=0 and all internal operand registers to 0.
REQ-029 Reset during DIVIDE or FIXUP SHALL abort the operation.
- No result_rdy pulse is produced for the aborted operation.
- The first start after rst deasserts SHALL be accepted normally.

Verification
REQ-030 Unsigned: X=100, Y=7 -> Quotient=14, Remainder=2; result_rdy exactly 33 edges after accept, busy high throughout.
REQ-031 Signed: X=0xFFFFFFF9 (-7), Y=2 -> Quotient=0xFFFFFFFD (-3), Remainder=0xFFFFFFFF (-1).
- Same operands unsigned -> Quotient=0x7FFFFFFC, Remainder=1.
REQ-032 Divide-by-zero: X=0x12345678, Y=0 -> Quotient=0xFFFFFFFF, Remainder=0x12345678, result_rdy 1 edge after accept.
REQ-033 Overflow: X=0x80000000, Y=0xFFFFFFFF:
- Signed -> Quotient=0x80000000, Remainder=0 after 1 edge.
- Unsigned -> Quotient=0, Remainder=0x80000000 after 33 edges.
REQ-034 Start X=1000, Y=10; pulse start with X=5, Y=5 at edge 10 -> ignored, Quotient=100, Remainder=0.
REQ-035 Assert rst at edge 12 of a divide -> outputs 0 and busy=0 at once, no result_rdy; a following X=9, Y=3 start yields Quotient=3, Remainder=0.
